piano_poly: RTL and testbench
=============================

# piano_poly

Parametrised polyphonic successor to the single-tone piano generator. Mixes up to VOICES simultaneous square-wave notes from a 16-entry half-period table. Notes arrive through a valid/ready key-event interface with press and release, and are allocated to free voices. The voice sum drives a 1-bit speaker pin through a first-order sigma-delta modulator, and is also exposed as a parallel mix count.

## Interface
- VOICES, 4: number of simultaneous voices (1..8).
- PERIOD_W, 18: half-period counter width.
- MIX_W, $clog2(VOICES+1): width of mix output (derived, not overridable).
- clk  in  1  system clock (50 MHz nominal; table values assume it).
- rst_n  in  1  reset, synchronous, active-low.
- hush  in  1  mute: forces mix and speaker to 0; voices keep running.
- key_valid  in  1  key event present.
- key_ready  out  1  key event accepted when key_valid && key_ready at posedge.
- key_on  in  1  1 = press (note-on), 0 = release (note-off).
- key_note  in  4  note index 0..15.
- busy  out  VOICES  bit v high while voice v is active.
- mix  out  MIX_W  registered count of active voices whose level is 1.
- speaker  out  1  sigma-delta PDM output.

## Operation
- Half-period table, note 0..15: 113635, 107257, 101237, 95555, 90192, 85130, 80352, 75842, 71585, 67568, 63775, 60196, 56817, 53628, 50618, 47777.
- Per-voice state: active, note[3:0], cnt[PERIOD_W-1:0], level.
- Active voice, each cycle:
  - If cnt == PERIOD[note]: cnt <= 0 and level toggles.
  - Otherwise cnt <= cnt+1.
  - Level therefore holds for PERIOD+1 cycles.
- Inactive voice: cnt = 0, level = 0.
- Note-on, accepted:
  - If an active voice already holds key_note, it is retriggered: cnt <= 0, level <= 0. No other voice changes.
  - Otherwise the lowest-index inactive voice is allocated (active <= 1, note <= key_note, cnt <= 0, level <= 0).
- Note-off: every active voice holding key_note is cleared to inactive. If no voice matches, nothing happens.
- At most one voice holds a given note, because retrigger takes priority over allocation.
- key_ready is combinational from key_on, key_note and voice state. It does not depend on key_valid, and is 0 while rst_n is low.
  - key_ready = 0 only for a note-on with no match and no free voice, and only when stealing is compiled out.
  - Note-off is always ready.
- Mixer, registered:
  - mix <= hush ? 0 : popcount(level & active).
  - Sigma-delta: acc (range 0..VOICES-1); sum = acc + mix. If sum >= VOICES then speaker <= 1 and acc <= sum - VOICES; otherwise speaker <= 0 and acc <= sum.
  - While hush is high: speaker <= 0, acc <= 0.
  - Long-run speaker duty is mix/VOICES. With VOICES=1, speaker equals the single voice level delayed.

## Timing
- Reset, synchronous: all voices inactive, cnt 0, level 0, busy 0, mix 0, speaker 0, acc 0, steal_ptr 0. This holds one cycle after the first posedge with rst_n low.
- Reset mid-note clears everything on that edge. Key events offered during reset are dropped.
- Note-on accepted at edge t:
  - busy[v] = 1 and cnt = 0 after t.
  - First level toggle is at edge t+1+PERIOD.
  - mix reflects the toggle one edge later; speaker reflects it one edge after mix.
- Note-off accepted at edge t: busy[v] = 0 and level = 0 after t. mix drops at t+1.
- hush takes effect on mix and speaker at the next edge. Releasing hush restarts the modulator from acc = 0.
- Events are one per cycle by construction. There is no queueing, and back-pressure stalls the source only for the full-and-no-steal case.

## Configuration
- PIANO_STEAL_EN defined: a note-on with all voices busy and no match is always accepted.
  - It replaces voice steal_ptr (cnt 0, level 0, new note).
  - steal_ptr then increments modulo VOICES.
  - steal_ptr advances only on steals.
- PIANO_STEAL_EN undefined: steal_ptr is absent, and key_ready = 0 for that case until a voice frees.

## Structure
- Package piano_pkg holds:
  - NOTE_W = 4.
  - PERIOD_W default.
  - The 16-entry PERIOD_LUT constant array.
  - A period lookup function.
- Sub-module piano_voice: one voice (active/note/cnt/level, load/retrigger/clear inputs, level output).
- Top piano_poly generates VOICES instances plus the allocator, mixer and modulator.

## Test plan
- Reset with rst_n low for 2 cycles mid-activity: busy=0, mix=0, speaker=0 after the first low edge, and key_ready=0 while rst_n is low.
- Single voice, VOICES=1: note 15 on at edge t → level toggles at t+47778 and t+95556; speaker mirrors level with 2-cycle delay; note-off → busy=0, speaker 0 within 2 edges.
- VOICES=4, notes 0,4,7 on → busy=0111 with voices allocated 0,1,2. Note 4 on again → retrigger voice 1 only (cnt=0), busy unchanged.
- Five distinct note-ons, steal compiled out: fifth sees key_ready=0. Note-off 0 → voice 0 frees and the fifth is then accepted into voice 0. With PIANO_STEAL_EN: the fifth is accepted into voice 0, and a sixth goes to voice 1.
- All 4 voices forced level=1: mix=4, speaker constant 1. With 2 high: speaker alternates 1,0, duty 50 %. Assert hush → mix=0, speaker=0 next edge while busy stays 1111.
- Note-off for a note not held: key_ready=1, accepted, no state change.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared constants, note half-period table and lookup helper for the polyphonic piano.
package piano_pkg;

    localparam int unsigned NOTE_W       = 4;
    localparam int unsigned PERIOD_W_DEF = 18;

    // Half-period in 50 MHz clock cycles. The first element listed is note 15.
    localparam logic [15:0][PERIOD_W_DEF-1:0] PERIOD_LUT = {
        18'd47777,  18'd50618,  18'd53628,  18'd56817,
        18'd60196,  18'd63775,  18'd67568,  18'd71585,
        18'd75842,  18'd80352,  18'd85130,  18'd90192,
        18'd95555,  18'd101237, 18'd107257, 18'd113635
    };

    function automatic logic [PERIOD_W_DEF-1:0] period_of(input logic [NOTE_W-1:0] note);
        return PERIOD_LUT[note];
    endfunction

endpackage

// File: rtl/piano_voice.sv
// One square-wave voice: holds note, half-period counter and output level.
// Priority of control inputs on the same edge: clear, then load, then retrigger.
module piano_voice
    import piano_pkg::*;
#(
    parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_retrig,
    input  logic              i_clear,
    input  logic [NOTE_W-1:0] i_note,
    output logic              o_active,
    output logic [NOTE_W-1:0] o_note,
    output logic              o_level
);

    logic                r_active;
    logic [NOTE_W-1:0]   r_note;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_level;

    logic                w_active_d;
    logic [NOTE_W-1:0]   w_note_d;
    logic [PERIOD_W-1:0] w_cnt_d;
    logic                w_level_d;
    logic [PERIOD_W-1:0] w_period;

    assign w_period = PERIOD_W'(period_of(r_note));

    // Next-state: free-running toggle counter, overridden by key-event controls.
    always_comb begin
        w_active_d = r_active;
        w_note_d   = r_note;
        w_cnt_d    = r_cnt;
        w_level_d  = r_level;
        if (!r_active) begin
            w_cnt_d   = '0;
            w_level_d = 1'b0;
        end else if (r_cnt == w_period) begin
            w_cnt_d   = '0;
            w_level_d = ~r_level;
        end else begin
            w_cnt_d = r_cnt + 1'b1;
        end
        if (i_clear) begin
            w_active_d = 1'b0;
            w_cnt_d    = '0;
            w_level_d  = 1'b0;
        end else if (i_load) begin
            w_active_d = 1'b1;
            w_note_d   = i_note;
            w_cnt_d    = '0;
            w_level_d  = 1'b0;
        end else if (i_retrig) begin
            w_cnt_d   = '0;
            w_level_d = 1'b0;
        end
    end

    // Voice state register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_note   <= '0;
            r_cnt    <= '0;
            r_level  <= 1'b0;
        end else begin
            r_active <= w_active_d;
            r_note   <= w_note_d;
            r_cnt    <= w_cnt_d;
            r_level  <= w_level_d;
        end
    end

    assign o_active = r_active;
    assign o_note   = r_note;
    assign o_level  = r_level;

endmodule

// File: rtl/piano_poly.sv
// Polyphonic square-wave piano: VOICES voices, key-event allocator, mixer and
// first-order sigma-delta speaker modulator.
// Optional: define PIANO_STEAL_EN to steal a voice round-robin when all are busy.
module piano_poly
    import piano_pkg::*;
#(
    parameter int unsigned VOICES   = 4,
    parameter int unsigned PERIOD_W = PERIOD_W_DEF,
    localparam int unsigned MIX_W   = $clog2(VOICES + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_hush,
    input  logic              i_key_valid,
    output logic              o_key_ready,
    input  logic              i_key_on,
    input  logic [NOTE_W-1:0] i_key_note,
    output logic [VOICES-1:0] o_busy,
    output logic [MIX_W-1:0]  o_mix,
    output logic              o_speaker
);

    localparam int unsigned IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    // Holds acc (< VOICES) + mix (<= VOICES) without overflow.
    localparam int unsigned SUM_W = MIX_W + 1;

    logic [VOICES-1:0] w_active;
    logic [VOICES-1:0] w_level;
    logic [VOICES-1:0] w_match;
    logic [VOICES-1:0] w_load;
    logic [VOICES-1:0] w_retrig;
    logic [VOICES-1:0] w_clear;
    logic [NOTE_W-1:0] w_note [VOICES];

    logic              w_any_match;
    logic              w_any_free;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_accept;

    logic [MIX_W-1:0]  r_mix;
    logic              r_speaker;
    logic [SUM_W-1:0]  r_acc;
    logic [MIX_W-1:0]  w_pop;
    logic [SUM_W-1:0]  w_sum;

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        piano_voice #(
            .PERIOD_W (PERIOD_W)
        ) u_voice (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_load   (w_load[v]),
            .i_retrig (w_retrig[v]),
            .i_clear  (w_clear[v]),
            .i_note   (i_key_note),
            .o_active (w_active[v]),
            .o_note   (w_note[v]),
            .o_level  (w_level[v])
        );
        assign w_match[v] = w_active[v] && (w_note[v] == i_key_note);
    end

    assign w_any_match = |w_match;
    assign w_any_free  = ~&w_active;

    // Lowest-index inactive voice.
    always_comb begin
        w_free_idx = '0;
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (!w_active[v]) begin
                w_free_idx = IDX_W'(v);
            end
        end
    end

`ifdef PIANO_STEAL_EN
    logic [IDX_W-1:0] r_steal_ptr;
    logic             w_steal;

    assign o_key_ready = i_rst_n;
`else
    assign o_key_ready = i_rst_n && (!i_key_on || w_any_match || w_any_free);
`endif

    assign w_accept = i_key_valid && o_key_ready;

    // Allocator: off clears matches; on retriggers a match, else allocates a free voice.
    always_comb begin
        w_load   = '0;
        w_retrig = '0;
        w_clear  = '0;
`ifdef PIANO_STEAL_EN
        w_steal  = 1'b0;
`endif
        if (w_accept) begin
            if (!i_key_on) begin
                w_clear = w_match;
            end else if (w_any_match) begin
                w_retrig = w_match;
            end else if (w_any_free) begin
                w_load[w_free_idx] = 1'b1;
`ifdef PIANO_STEAL_EN
            end else begin
                w_load[r_steal_ptr] = 1'b1;
                w_steal             = 1'b1;
`endif
            end
        end
    end

`ifdef PIANO_STEAL_EN
    // Round-robin steal pointer, advanced only when a voice is stolen.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_steal_ptr <= '0;
        end else if (w_steal) begin
            r_steal_ptr <= (r_steal_ptr == IDX_W'(VOICES - 1)) ? '0 : r_steal_ptr + 1'b1;
        end
    end
`endif

    // Count of active voices currently high.
    always_comb begin
        w_pop = '0;
        for (int v = 0; v < VOICES; v++) begin
            w_pop = w_pop + MIX_W'(w_level[v] & w_active[v]);
        end
    end

    assign w_sum = r_acc + SUM_W'(r_mix);

    // Registered mix and sigma-delta modulator; hush zeroes outputs and accumulator.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mix     <= '0;
            r_speaker <= 1'b0;
            r_acc     <= '0;
        end else if (i_hush) begin
            r_mix     <= '0;
            r_speaker <= 1'b0;
            r_acc     <= '0;
        end else begin
            r_mix <= w_pop;
            if (w_sum >= SUM_W'(VOICES)) begin
                r_speaker <= 1'b1;
                r_acc     <= w_sum - SUM_W'(VOICES);
            end else begin
                r_speaker <= 1'b0;
                r_acc     <= w_sum;
            end
        end
    end

    assign o_busy    = w_active;
    assign o_mix     = r_mix;
    assign o_speaker = r_speaker;

endmodule

// File: tb/tb_piano_poly.sv
// Randomised scoreboard bench for piano_poly (VOICES=4). A driver applies key
// events, advances a time-based reference model and queues the expected
// outputs; a monitor on the falling edge pops and compares them.
module tb_piano_poly;

    localparam int V      = 4;
    localparam int TOTAL  = 60700;

    logic       clk;
    logic       rst_n;
    logic       hush;
    logic       key_valid;
    logic       key_ready;
    logic       key_on;
    logic [3:0] key_note;
    logic [V-1:0] busy;
    logic [2:0] mix;
    logic       speaker;

    piano_poly #(
        .VOICES (V)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_hush      (hush),
        .i_key_valid (key_valid),
        .o_key_ready (key_ready),
        .i_key_on    (key_on),
        .i_key_note  (key_note),
        .o_busy      (busy),
        .o_mix       (mix),
        .o_speaker   (speaker)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a voice is described by its note and the edge it (re)started on.
    int unsigned per [16] = '{113635, 107257, 101237, 95555, 90192, 85130, 80352, 75842,
                              71585, 67568, 63775, 60196, 56817, 53628, 50618, 47777};
    bit     m_act [V];
    int     m_note[V];
    longint m_t0  [V];
    longint now;
    int     m_mix;
    int     m_acc;
    bit     m_spk;
    int     m_sptr;

    typedef struct {
        logic [V-1:0] busy;
        int           mix;
        bit           spk;
        bit           rdy;
    } exp_t;

    exp_t q[$];
    int   n_vec;
    int   n_miss;

    // Square wave: level flips every PERIOD+1 edges after the start edge.
    function automatic bit m_lvl(int v);
        if (!m_act[v]) return 1'b0;
        return (((now - m_t0[v]) / longint'(per[m_note[v]] + 1)) % 2) == 1;
    endfunction

    function automatic bit m_ready(bit rst, bit on, int note);
        bit any_match;
        bit any_free;
        if (!rst) return 1'b0;
        if (!on) return 1'b1;
`ifdef PIANO_STEAL_EN
        return 1'b1;
`else
        any_match = 1'b0;
        any_free  = 1'b0;
        for (int v = 0; v < V; v++) begin
            if (m_act[v] && m_note[v] == note) any_match = 1'b1;
            if (!m_act[v]) any_free = 1'b1;
        end
        return any_match || any_free;
`endif
    endfunction

    task automatic model_edge();
        bit acc_evt;
        int lv;
        int sum;
        int k;
        int hit;
        k       = int'(key_note);
        acc_evt = key_valid && m_ready(rst_n, key_on, k);
        lv = 0;
        for (int v = 0; v < V; v++) lv += int'(m_lvl(v));
        now++;
        if (!rst_n) begin
            for (int v = 0; v < V; v++) m_act[v] = 1'b0;
            m_mix  = 0;
            m_acc  = 0;
            m_spk  = 1'b0;
            m_sptr = 0;
            return;
        end
        sum = m_acc + m_mix;
        if (hush) begin
            m_spk = 1'b0;
            m_acc = 0;
        end else if (sum >= V) begin
            m_spk = 1'b1;
            m_acc = sum - V;
        end else begin
            m_spk = 1'b0;
            m_acc = sum;
        end
        m_mix = hush ? 0 : lv;
        if (!acc_evt) return;
        if (!key_on) begin
            for (int v = 0; v < V; v++)
                if (m_act[v] && m_note[v] == k) m_act[v] = 1'b0;
            return;
        end
        hit = -1;
        for (int v = 0; v < V; v++)
            if (m_act[v] && m_note[v] == k) hit = v;
        if (hit >= 0) begin
            m_t0[hit] = now;
            return;
        end
        for (int v = V - 1; v >= 0; v--)
            if (!m_act[v]) hit = v;
        if (hit < 0) begin
            hit    = m_sptr;
            m_sptr = (m_sptr + 1) % V;
        end
        m_act[hit]  = 1'b1;
        m_note[hit] = k;
        m_t0[hit]   = now;
    endtask

    task automatic push_expect();
        exp_t e;
        for (int v = 0; v < V; v++) e.busy[v] = m_act[v];
        e.mix = m_mix;
        e.spk = m_spk;
        e.rdy = m_ready(rst_n, key_on, int'(key_note));
        q.push_back(e);
    endtask

    // Driver: model the edge just taken, then drive the next cycle's inputs.
    initial begin
        exp_t dummy;
        rst_n     = 1'b0;
        hush      = 1'b0;
        key_valid = 1'b1;
        key_on    = 1'b1;
        key_note  = 4'd3;
        now       = 0;
        n_vec     = 0;
        n_miss    = 0;
        for (int c = 0; c < TOTAL; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            key_valid = 1'b0;
            key_on    = 1'($urandom_range(0, 1));
            key_note  = 4'($urandom_range(0, 15));
            hush      = 1'b0;
            rst_n     = 1'b1;
            if (c < 1 || c == 250 || c == 251 || c == 396 || c == 397) begin
                rst_n     = 1'b0;
                key_valid = 1'($urandom_range(0, 1));
                key_on    = 1'b1;
            end else if (c < 396) begin
                key_valid = ($urandom_range(0, 3) != 0);
                key_on    = ($urandom_range(0, 2) != 0);
                key_note  = 4'($urandom_range(0, 5));
                hush      = ($urandom_range(0, 15) == 0);
            end else if (c < 402) begin
                key_valid = 1'b1;
                key_on    = 1'b1;
                key_note  = 4'(15 - (c - 398));
            end else if (c < 60400) begin
                hush = (c >= 55000 && c < 55100) || (c >= 58000 && c < 58010);
            end else begin
                key_valid = ($urandom_range(0, 1) != 0);
                key_on    = ($urandom_range(0, 2) != 0);
                key_note  = 4'($urandom_range(0, 15));
                hush      = ($urandom_range(0, 31) == 0);
            end
            push_expect();
        end
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
            while (q.size() != 0) dummy = q.pop_front();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Monitor: compare DUT outputs with the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (busy !== e.busy) begin
                n_miss++;
                $display("FAIL busy @%0t: got %b want %b", $time, busy, e.busy);
            end
            if (mix !== 3'(e.mix)) begin
                n_miss++;
                $display("FAIL mix @%0t: got %0d want %0d", $time, mix, e.mix);
            end
            if (speaker !== e.spk) begin
                n_miss++;
                $display("FAIL speaker @%0t: got %b want %b", $time, speaker, e.spk);
            end
            if (key_ready !== e.rdy) begin
                n_miss++;
                $display("FAIL key_ready @%0t: got %b want %b", $time, key_ready, e.rdy);
            end
        end
    end

endmodule
